bicubic_coord_gen: RTL and testbench

Upstream address/phase generator for the bicubic scaler datapath. For every output pixel of a frame it computes the centre-aligned source coordinate in fixed point, splits it into a signed integer tap index and an 8-bit phase, and streams (x_idx, x_blend, y_idx, y_blend) plus framing flags over a valid/ready interface. The line-buffer tap fetch consumes the indices; the per-tap weight stages consume the blend values, with coeffOne = 256 and coeffHalf = 128.

---
 rtl/bicubic_pkg.sv | 28 ++
 rtl/bicubic_axis_acc.sv | 47 ++++
 rtl/bicubic_coord_gen.sv | 123 ++++++++++++
 tb/tb_bicubic_coord_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants, state encoding and initial-phase helper for the bicubic
// scaler coordinate generator.
package bicubic_pkg;

    localparam int IDX_W      = 12;
    localparam int STEP_FRAC  = 12;
    localparam int BLEND_W    = 8;
    localparam int STEP_W     = 16;
    localparam int ACC_W      = IDX_W + STEP_FRAC + 1;
    localparam int COEFF_ONE  = 256;
    localparam int COEFF_HALF = 128;
    localparam int HALF_Q12   = 2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FIN
    } state_e;

    // Centre-aligned start position: half a source step minus half a pixel.
    function automatic logic signed [ACC_W-1:0] initAcc(input logic [STEP_W-1:0] step);
        logic signed [ACC_W-1:0] half;
        half = ACC_W'(HALF_Q12);
        return $signed({{(ACC_W-STEP_W+1){1'b0}}, step[STEP_W-1:1]}) - half;
    endfunction

endpackage

// File: rtl/bicubic_axis_acc.sv
// One axis of the coordinate generator: fixed-point position accumulator and
// beat counter, split into a signed integer tap index and a blend phase.
module bicubic_axis_acc
    import bicubic_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STEP_W-1:0]       step_i,
    input  logic                    load_init_i,
    input  logic                    advance_i,
    input  logic                    wrap_i,
    output logic signed [IDX_W:0]   idx_o,
    output logic [BLEND_W:0]        blend_o,
    output logic [IDX_W-1:0]        cnt_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_init_i || wrap_i) begin
            acc_d = initAcc(step_i);
            cnt_d = '0;
        end else if (advance_i) begin
            acc_d = acc_q + $signed({{(ACC_W-STEP_W){1'b0}}, step_i});
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Taking the upper bits of a two's-complement value is a floor, not a truncation toward zero.
    assign idx_o   = acc_q[ACC_W-1:STEP_FRAC];
    assign blend_o = {1'b0, acc_q[STEP_FRAC-1 -: BLEND_W]};
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/bicubic_coord_gen.sv
// Per-output-pixel source coordinate and phase generator streaming tap
// indices, blend phases and framing flags over valid/ready.
module bicubic_coord_gen
    import bicubic_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [IDX_W-1:0]        dst_width_i,
    input  logic [IDX_W-1:0]        dst_height_i,
    input  logic [STEP_W-1:0]       step_x_i,
    input  logic [STEP_W-1:0]       step_y_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [IDX_W:0]   out_x_idx_o,
    output logic [BLEND_W:0]        out_x_blend_o,
    output logic signed [IDX_W:0]   out_y_idx_o,
    output logic [BLEND_W:0]        out_y_blend_o,
    output logic                    out_sof_o,
    output logic                    out_eof_o,
    output logic                    out_sol_o,
    output logic                    out_eol_o
);

    state_e              state_q;
    logic                valid_q, busy_q, done_q;
    logic [IDX_W-1:0]    width_q, height_q;
    logic [STEP_W-1:0]   step_x_q, step_y_q;

    logic signed [IDX_W:0] x_idx, y_idx;
    logic [BLEND_W:0]      x_blend, y_blend;
    logic [IDX_W-1:0]      x_cnt, y_cnt;
    logic                  fire, load_init, x_eol, y_last;

    assign fire      = valid_q && out_ready_i;
    assign load_init = (state_q == ST_INIT);
    assign x_eol     = (x_cnt == width_q - IDX_W'(1));
    assign y_last    = (y_cnt == height_q - IDX_W'(1));

    bicubic_axis_acc u_x_axis (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .step_i      (step_x_q),
        .load_init_i (load_init),
        .advance_i   (fire && !x_eol),
        .wrap_i      (fire && x_eol),
        .idx_o       (x_idx),
        .blend_o     (x_blend),
        .cnt_o       (x_cnt)
    );

    bicubic_axis_acc u_y_axis (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .step_i      (step_y_q),
        .load_init_i (load_init),
        .advance_i   (fire && x_eol),
        .wrap_i      (1'b0),
        .idx_o       (y_idx),
        .blend_o     (y_blend),
        .cnt_o       (y_cnt)
    );

    // A zero-sized frame skips straight to FIN so done still pulses exactly once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        width_q  <= dst_width_i;
                        height_q <= dst_height_i;
                        step_x_q <= step_x_i;
                        step_y_q <= step_y_i;
                        busy_q   <= 1'b1;
                        state_q  <= (dst_width_i == '0 || dst_height_i == '0) ? ST_FIN : ST_INIT;
                    end
                end
                ST_INIT: begin
                    valid_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (fire && x_eol && y_last) begin
                        valid_q <= 1'b0;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Fields are forced to zero whenever no beat is offered.
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign out_valid_o   = valid_q;
    assign out_x_idx_o   = valid_q ? x_idx : '0;
    assign out_x_blend_o = valid_q ? x_blend : '0;
    assign out_y_idx_o   = valid_q ? y_idx : '0;
    assign out_y_blend_o = valid_q ? y_blend : '0;
    assign out_sol_o     = valid_q && (x_cnt == '0);
    assign out_eol_o     = valid_q && x_eol;
    assign out_sof_o     = out_sol_o && (y_cnt == '0);
    assign out_eof_o     = out_eol_o && y_last;

endmodule

// File: tb/tb_bicubic_coord_gen.sv
// Directed-vector bench for bicubic_coord_gen: table of hand-computed beats
// plus stall, zero-size and mid-frame reset sequences.
module tb_bicubic_coord_gen;
    import bicubic_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [IDX_W-1:0]      dst_width, dst_height;
    logic [STEP_W-1:0]     step_x, step_y;
    logic                  busy, done, out_valid, out_ready;
    logic signed [IDX_W:0] out_x_idx, out_y_idx;
    logic [BLEND_W:0]      out_x_blend, out_y_blend;
    logic                  out_sof, out_eof, out_sol, out_eol;

    int checks = 0;
    int passes = 0;

    // flags are {sof, eof, sol, eol}
    typedef struct {
        logic [15:0] sx;
        logic [15:0] sy;
        int          w;
        int          h;
        int          xi;
        int          xb;
        int          yi;
        int          yb;
        logic [3:0]  flags;
    } beat_t;

    beat_t vecs[$];

    bicubic_coord_gen dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dst_width_i   (dst_width),
        .dst_height_i  (dst_height),
        .step_x_i      (step_x),
        .step_y_i      (step_y),
        .busy_o        (busy),
        .done_o        (done),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_x_idx_o   (out_x_idx),
        .out_x_blend_o (out_x_blend),
        .out_y_idx_o   (out_y_idx),
        .out_y_blend_o (out_y_blend),
        .out_sof_o     (out_sof),
        .out_eof_o     (out_eof),
        .out_sol_o     (out_sol),
        .out_eol_o     (out_eol)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy, input int w, input int h);
        @(negedge clk);
        step_x     = sx;
        step_y     = sy;
        dst_width  = IDX_W'(w);
        dst_height = IDX_W'(h);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitValid(output int waited, output int ok);
        waited = 0;
        ok     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic int flagsNow();
        return int'({out_sof, out_eof, out_sol, out_eol});
    endfunction

    task automatic checkDoneTail();
        @(negedge clk);
        checkOutput("tail valid low", int'(out_valid), 0);
        checkOutput("tail busy in FIN", int'(busy), 1);
        checkOutput("tail done early", int'(done), 0);
        @(negedge clk);
        checkOutput("done pulse", int'(done), 1);
        checkOutput("busy after done", int'(busy), 0);
        @(negedge clk);
        checkOutput("done single cycle", int'(done), 0);
    endtask

    initial begin
        int waited, ok, accepted, stallErr, k, doneSeen, validSeen;
        int readyPat[4];
        logic stalled;
        int sx0, sb0, sy0, syb0, sf0;

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        dst_width = '0; dst_height = '0; step_x = '0; step_y = '0;

        // 4x2 at unity scale
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 0, 0, 0, 0, 4'b1010});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 1, 0, 0, 0, 4'b0000});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 2, 0, 0, 0, 4'b0000});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 3, 0, 0, 0, 4'b0001});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 0, 0, 1, 0, 4'b0010});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 1, 0, 1, 0, 4'b0000});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 2, 0, 1, 0, 4'b0000});
        vecs.push_back('{16'd4096, 16'd4096, 4, 2, 3, 0, 1, 0, 4'b0101});
        // 2x upscale: starts at -0.25
        vecs.push_back('{16'd2048, 16'd4096, 4, 1, -1, 192, 0, 0, 4'b1010});
        vecs.push_back('{16'd2048, 16'd4096, 4, 1,  0,  64, 0, 0, 4'b0000});
        vecs.push_back('{16'd2048, 16'd4096, 4, 1,  0, 192, 0, 0, 4'b0000});
        vecs.push_back('{16'd2048, 16'd4096, 4, 1,  1,  64, 0, 0, 4'b0101});
        // 2x downscale
        vecs.push_back('{16'd8192, 16'd4096, 3, 1, 0, 128, 0, 0, 4'b1010});
        vecs.push_back('{16'd8192, 16'd4096, 3, 1, 2, 128, 0, 0, 4'b0000});
        vecs.push_back('{16'd8192, 16'd4096, 3, 1, 4, 128, 0, 0, 4'b0101});
        // single-column frame, vertical 2x upscale
        vecs.push_back('{16'd4096, 16'd2048, 1, 3, 0, 0, -1, 192, 4'b1011});
        vecs.push_back('{16'd4096, 16'd2048, 1, 3, 0, 0,  0,  64, 4'b0011});
        vecs.push_back('{16'd4096, 16'd2048, 1, 3, 0, 0,  0, 192, 4'b0111});

        repeat (3) @(negedge clk);
        checkOutput("reset valid", int'(out_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset flags", flagsNow(), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle done", int'(done), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].flags[3]) applyStimulus(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h);
            waitValid(waited, ok);
            checkOutput("beat present", ok, 1);
            checkOutput(vecs[i].flags[3] ? "first beat latency" : "beat spacing", waited, 1);
            if (ok == 1) begin
                checkOutput("x_idx", int'(out_x_idx), vecs[i].xi);
                checkOutput("x_blend", int'(out_x_blend), vecs[i].xb);
                checkOutput("y_idx", int'(out_y_idx), vecs[i].yi);
                checkOutput("y_blend", int'(out_y_blend), vecs[i].yb);
                checkOutput("flags", flagsNow(), int'(vecs[i].flags));
            end
            if (vecs[i].flags[2]) checkDoneTail();
        end

        // Backpressure with ready pattern 1,0,0,1 over a 4x2 frame.
        readyPat = '{1, 0, 0, 1};
        out_ready = 1'b0;
        applyStimulus(16'd4096, 16'd4096, 4, 2);
        accepted = 0; stallErr = 0; k = 0; doneSeen = 0; stalled = 1'b0;
        sx0 = 0; sb0 = 0; sy0 = 0; syb0 = 0; sf0 = 0;
        for (int c = 0; c < 100 && doneSeen == 0; c++) begin
            @(negedge clk);
            if (done) doneSeen = 1;
            if (stalled && (int'(out_x_idx) != sx0 || int'(out_x_blend) != sb0 ||
                            int'(out_y_idx) != sy0 || int'(out_y_blend) != syb0 ||
                            flagsNow() != sf0 || !out_valid))
                stallErr++;
            out_ready = readyPat[k % 4] != 0;
            k++;
            stalled = out_valid && !out_ready;
            sx0 = int'(out_x_idx); sb0 = int'(out_x_blend);
            sy0 = int'(out_y_idx); syb0 = int'(out_y_blend); sf0 = flagsNow();
            if (out_valid && out_ready) begin
                checkOutput("stall x_idx", int'(out_x_idx), accepted % 4);
                checkOutput("stall y_idx", int'(out_y_idx), accepted / 4);
                accepted++;
            end
        end
        out_ready = 1'b1;
        checkOutput("stall beat count", accepted, 8);
        checkOutput("stall stability", stallErr, 0);
        checkOutput("stall done seen", doneSeen, 1);

        // Zero width: no beats, done two cycles after start, start ignored while busy.
        applyStimulus(16'd4096, 16'd4096, 0, 2);
        validSeen = int'(out_valid);
        checkOutput("zero busy", int'(busy), 1);
        checkOutput("zero done early", int'(done), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        validSeen |= int'(out_valid);
        checkOutput("zero done pulse", int'(done), 1);
        @(negedge clk);
        validSeen |= int'(out_valid);
        checkOutput("zero busy start ignored", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            validSeen |= int'(out_valid);
        end
        checkOutput("zero no valid", validSeen, 0);

        // Reset after three beats of a 4x2 frame.
        applyStimulus(16'd4096, 16'd4096, 4, 2);
        for (int b = 0; b < 3; b++) waitValid(waited, ok);
        checkOutput("pre-reset x_idx", int'(out_x_idx), 2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst valid", int'(out_valid), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        checkOutput("rst x_idx", int'(out_x_idx), 0);
        checkOutput("rst flags", flagsNow(), 0);
        rst = 1'b0;
        doneSeen = 0; validSeen = 0;
        repeat (5) begin
            @(negedge clk);
            doneSeen |= int'(done);
            validSeen |= int'(out_valid);
        end
        checkOutput("rst no done", doneSeen, 0);
        checkOutput("rst no valid", validSeen, 0);
        applyStimulus(16'd2048, 16'd4096, 4, 1);
        waitValid(waited, ok);
        checkOutput("restart latency", waited, 1);
        checkOutput("restart x_idx", int'(out_x_idx), -1);
        checkOutput("restart x_blend", int'(out_x_blend), 192);
        checkOutput("restart y_idx", int'(out_y_idx), 0);
        checkOutput("restart flags", flagsNow(), 4'b1010);
        repeat (3) waitValid(waited, ok);
        checkOutput("restart last x_idx", int'(out_x_idx), 1);
        checkDoneTail();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
